addr_decode_ws: RTL and testbench



---
 rtl/addr_decode_ws.sv | 107 ++++++++++
 tb/tb_addr_decode_ws.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/addr_decode_ws.sv
// Registered base/mask address decoder for the 6502 bus.
// It drives a one-hot chip select, per-region wait states on RDY and a sticky unmapped-access flag.
module addr_decode_ws #(
    parameter int                          ADDR_W      = 16,
    parameter int                          N_REG       = 3,
    parameter int                          WAIT_W      = 4,
    parameter logic [N_REG*ADDR_W-1:0]     REGION_BASE = {16'h0000, 16'h8000, 16'h7ff0},
    parameter logic [N_REG*ADDR_W-1:0]     REGION_MASK = {16'h8000, 16'h8000, 16'hfffe},
    parameter logic [N_REG*WAIT_W-1:0]     REGION_WAIT = {4'd0, 4'd2, 4'd1}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              access_start,
    input  logic [N_REG-1:0]  region_en,
    output logic [N_REG-1:0]  cs,
    output logic              rdy,
    output logic              unmapped,
    input  logic              unmapped_clr
);

    generate
        if (N_REG < 1 || ADDR_W < 1) begin : g_param_check
            $fatal(1, "addr_decode_ws: N_REG and ADDR_W must both be >= 1");
        end
    endgenerate

    logic [N_REG-1:0]  sel;
    logic [WAIT_W-1:0] sel_wait;
    logic [N_REG-1:0]  cs_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rdy_q;
    logic              unmapped_q;
    logic              accept;
    logic              cs_consistent;

    // Walk from the highest index down so the lowest matching index wins.
    always_comb begin
        sel      = '0;
        sel_wait = '0;
        for (int k = N_REG - 1; k >= 0; k--) begin
            if (region_en[k] &&
                ((addr & REGION_MASK[k*ADDR_W +: ADDR_W]) == REGION_BASE[k*ADDR_W +: ADDR_W])) begin
                sel      = '0;
                sel[k]   = 1'b1;
                sel_wait = REGION_WAIT[k*WAIT_W +: WAIT_W];
            end
        end
    end

    // Handshake: access_start is a one-clock request, accepted only while
    // wait_cnt==0. rdy is low for exactly the region's wait count after acceptance.
    // A request made while rdy is low is dropped.
    assign accept = access_start && (wait_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q       <= '0;
            addr_q     <= '0;
            wait_cnt   <= '0;
            rdy_q      <= 1'b1;
            unmapped_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= addr;
                cs_q     <= sel;
                wait_cnt <= sel_wait;
                rdy_q    <= (sel_wait == '0);
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
                rdy_q    <= (wait_cnt == WAIT_W'(1));
            end else begin
                rdy_q    <= 1'b1;
            end

            // A no-match access beats a simultaneous clear.
            if (accept && (sel == '0)) begin
                unmapped_q <= 1'b1;
            end else if (unmapped_clr) begin
                unmapped_q <= 1'b0;
            end
        end
    end

    // The held chip select must always belong to the latched address.
    always_comb begin
        cs_consistent = 1'b1;
        for (int k = 0; k < N_REG; k++) begin
            if (cs_q[k] &&
                ((addr_q & REGION_MASK[k*ADDR_W +: ADDR_W]) != REGION_BASE[k*ADDR_W +: ADDR_W])) begin
                cs_consistent = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (cs_consistent && $onehot0(cs_q));
        end
    end

    assign cs       = cs_q;
    assign rdy      = rdy_q;
    assign unmapped = unmapped_q;

endmodule

// File: tb/tb_addr_decode_ws.sv
// Directed bench for addr_decode_ws: a decode/wait-state vector table, an address sweep
// and hand-written sequences for stalls, unmapped handling and async reset.
module tb_addr_decode_ws;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic        access_start;
    logic [2:0]  region_en;
    logic [2:0]  cs;
    logic        rdy;
    logic        unmapped;
    logic        unmapped_clr;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    addr_decode_ws dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .access_start (access_start),
        .region_en    (region_en),
        .cs           (cs),
        .rdy          (rdy),
        .unmapped     (unmapped),
        .unmapped_clr (unmapped_clr)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  en;
        logic        clr;
        logic [2:0]  exp_cs;
        int          exp_wait;
        logic        exp_unm;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Starts one access on the next edge; returns 1 time unit after the accepting edge.
    task automatic do_access(input logic [15:0] a, input logic [2:0] en, input logic clr);
        @(posedge clk);
        #1;
        addr         = a;
        region_en    = en;
        unmapped_clr = clr;
        access_start = 1'b1;
        @(posedge clk);
        #1;
        access_start = 1'b0;
        unmapped_clr = 1'b0;
    endtask

    // Counts clocks with rdy low, bounded so a stuck rdy cannot hang the run.
    task automatic wait_rdy(output int n);
        n = 0;
        while (!rdy && n < 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 16) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: rdy still 0 after %0d clocks", n);
        end
    endtask

    function automatic logic [2:0] ref_cs(input int a);
        if (a >= 32'h8000)                    return 3'b010;
        if (a == 32'h7ff0 || a == 32'h7ff1)   return 3'b001;
        return 3'b100;
    endfunction

    initial begin
        int n;
        int low;
        logic [2:0] exp_cs;

        vecs[0]  = '{16'h0000, 3'b111, 1'b0, 3'b100, 0, 1'b0};
        vecs[1]  = '{16'h7fef, 3'b111, 1'b0, 3'b100, 0, 1'b0};
        vecs[2]  = '{16'h7ff0, 3'b111, 1'b0, 3'b001, 1, 1'b0};
        vecs[3]  = '{16'h7ff1, 3'b111, 1'b0, 3'b001, 1, 1'b0};
        vecs[4]  = '{16'h7ff2, 3'b111, 1'b0, 3'b100, 0, 1'b0};
        vecs[5]  = '{16'h7fff, 3'b111, 1'b0, 3'b100, 0, 1'b0};
        vecs[6]  = '{16'h8000, 3'b111, 1'b0, 3'b010, 2, 1'b0};
        vecs[7]  = '{16'h9000, 3'b111, 1'b0, 3'b010, 2, 1'b0};
        vecs[8]  = '{16'hffff, 3'b111, 1'b0, 3'b010, 2, 1'b0};
        vecs[9]  = '{16'h1234, 3'b111, 1'b0, 3'b100, 0, 1'b0};
        vecs[10] = '{16'h8000, 3'b101, 1'b0, 3'b000, 0, 1'b1};
        vecs[11] = '{16'h0010, 3'b101, 1'b0, 3'b100, 0, 1'b1};
        vecs[12] = '{16'h7ff0, 3'b110, 1'b0, 3'b100, 0, 1'b1};
        vecs[13] = '{16'h1234, 3'b011, 1'b1, 3'b000, 0, 1'b1};
        vecs[14] = '{16'h0000, 3'b111, 1'b1, 3'b100, 0, 1'b0};
        vecs[15] = '{16'h7ff0, 3'b011, 1'b0, 3'b001, 1, 1'b0};
        vecs[16] = '{16'h8000, 3'b000, 1'b0, 3'b000, 0, 1'b1};
        vecs[17] = '{16'hc000, 3'b111, 1'b1, 3'b010, 2, 1'b0};

        rst_n        = 1'b0;
        addr         = '0;
        access_start = 1'b0;
        region_en    = 3'b111;
        unmapped_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cs", 32'(cs), 32'(3'b000));
        check("reset_rdy", 32'(rdy), 32'(1'b1));
        check("reset_unmapped", 32'(unmapped), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_cs", 32'(cs), 32'(3'b000));
        check("idle_rdy", 32'(rdy), 32'(1'b1));

        // Vector table: decode, wait-state length and sticky flag.
        for (int i = 0; i < 18; i++) begin
            do_access(vecs[i].addr, vecs[i].en, vecs[i].clr);
            check($sformatf("vec%0d_cs", i), 32'(cs), 32'(vecs[i].exp_cs));
            check($sformatf("vec%0d_unmapped", i), 32'(unmapped), 32'(vecs[i].exp_unm));
            wait_rdy(n);
            check($sformatf("vec%0d_wait", i), 32'(n), 32'(vecs[i].exp_wait));
        end

        // Clear alone drops the flag on the next edge and leaves cs untouched.
        do_access(16'h8000, 3'b101, 1'b0);
        check("clr_pre_unmapped", 32'(unmapped), 32'(1'b1));
        @(posedge clk);
        #1;
        unmapped_clr = 1'b1;
        @(posedge clk);
        #1;
        unmapped_clr = 1'b0;
        check("clr_unmapped", 32'(unmapped), 32'(1'b0));
        check("clr_cs", 32'(cs), 32'(3'b000));

        // Address sweep with the default map: always exactly one select, never unmapped.
        for (int a = 0; a < 65536; a += 37) begin
            exp_q.push_back(ref_cs(a));
            do_access(16'(a), 3'b111, 1'b0);
            exp_cs = exp_q.pop_front();
            check($sformatf("sweep_%04h_cs", a), 32'(cs), 32'(exp_cs));
            check($sformatf("sweep_%04h_onehot", a), 32'($countones(cs)), 32'd1);
            check($sformatf("sweep_%04h_unmapped", a), 32'(unmapped), 32'(1'b0));
            wait_rdy(n);
        end
        do_access(16'h7fff, 3'b111, 1'b0);
        check("sweep_top_ram", 32'(cs), 32'(3'b100));
        wait_rdy(n);

        // Request during a stall is dropped; the original wait completes.
        do_access(16'hc000, 3'b111, 1'b0);
        low = 0;
        if (!rdy) low++;
        addr         = 16'h0000;
        access_start = 1'b1;
        @(posedge clk);
        #1;
        access_start = 1'b0;
        check("stall_cs_held", 32'(cs), 32'(3'b010));
        while (!rdy && low < 16) begin
            low++;
            @(posedge clk);
            #1;
        end
        check("stall_wait_len", 32'(low), 32'd2);
        check("stall_rdy_back", 32'(rdy), 32'(1'b1));
        @(posedge clk);
        #1;
        check("stall_cs_after", 32'(cs), 32'(3'b010));

        // Asynchronous reset in the middle of a wait.
        do_access(16'hc000, 3'b111, 1'b0);
        check("arst_pre_rdy", 32'(rdy), 32'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdy", 32'(rdy), 32'(1'b1));
        check("arst_cs", 32'(cs), 32'(3'b000));
        check("arst_unmapped", 32'(unmapped), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        do_access(16'h0000, 3'b111, 1'b0);
        check("post_rst_cs", 32'(cs), 32'(3'b100));
        check("post_rst_rdy", 32'(rdy), 32'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
